// File: rtl/msb_drain_sched_pkg.sv
// rtl/msb_drain_sched_pkg.sv - shared constants, state enum and width helper for msb_drain_sched
package msb_drain_sched_pkg;

  localparam int N_DEFAULT = 32;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

  localparam int IW_DEFAULT = clog2(N_DEFAULT);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/msb_drain_sched_if.sv
// rtl/msb_drain_sched_if.sv - request-in / grant-out handshake bundle for msb_drain_sched
interface msb_drain_sched_if
  import msb_drain_sched_pkg::*;
#(
  parameter int N = 32
) ();

  localparam int IW = clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_word;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_onehot;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic [IW:0]   out_count;
  logic          busy;

  // Side that supplies words and consumes grants.
  modport master (
    output in_valid, in_word, flush, out_ready,
    input  in_ready, out_valid, out_onehot, out_index, out_last, out_count, busy
  );

  // The scheduler itself.
  modport slave (
    input  in_valid, in_word, flush, out_ready,
    output in_ready, out_valid, out_onehot, out_index, out_last, out_count, busy
  );

endinterface

// File: rtl/msb_drain_sched_onehot_to_index.sv
// rtl/msb_drain_sched_onehot_to_index.sv - one-hot to binary index encoder
module onehot_to_index
  import msb_drain_sched_pkg::*;
#(
  parameter int N = 32,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  onehot,
  output logic [IW-1:0] index
);

  // Each index bit is the OR of every one-hot position whose number has that bit set.
  always_comb begin
    index = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) begin
        index = index | IW'(i);
      end
    end
  end

endmodule

// File: rtl/msb_mask.sv
// rtl/msb_mask.sv - isolate the highest set bit of a 32-bit word
module msb_mask (
  input  logic [31:0] word,
  output logic [31:0] msb
);

  logic [31:0] smear;

  // Smear the top set bit downwards, then keep only the edge of the smear.
  always_comb begin
    smear = word;
    smear = smear | (smear >> 1);
    smear = smear | (smear >> 2);
    smear = smear | (smear >> 4);
    smear = smear | (smear >> 8);
    smear = smear | (smear >> 16);
    msb   = smear & ~(smear >> 1);
  end

endmodule

// File: rtl/msb_drain_sched.sv
// rtl/msb_drain_sched.sv - emit the set bits of a request word one per beat, MSB first
module msb_drain_sched
  import msb_drain_sched_pkg::*;
#(
  parameter int N = 32
) (
  input logic               clk,
  input logic               rst,
  msb_drain_sched_if.slave  bus
);

  localparam int IW = clog2(N);

  state_t        state;
  logic [N-1:0]  resid;
  logic [IW:0]   count;

  logic [31:0]   resid_ext;
  logic [31:0]   msb_ext;
  logic [N-1:0]  top_bit;
  logic [IW-1:0] top_index;
  logic          draining;
  logic          last;
  logic          fire;
  logic          flush_drain;
  logic          ready;
  logic          accept;
  logic          load;

  assign resid_ext = 32'(resid);

  msb_mask u_msb_mask (
    .word (resid_ext),
    .msb  (msb_ext)
  );

  assign top_bit = msb_ext[N-1:0];

  onehot_to_index #(.N(N)) u_onehot_to_index (
    .onehot (top_bit),
    .index  (top_index)
  );

  assign draining    = (state == DRAIN);
  assign last        = draining && ((resid & ~top_bit) == '0);
  assign fire        = draining && bus.out_ready;
  assign flush_drain = bus.flush && draining;
  // A new word may enter while the final beat leaves, or while a flush discards the current one.
  assign ready       = !draining || (fire && last) || flush_drain;
  assign accept      = bus.in_valid && ready;
  assign load        = accept && (bus.in_word != '0);

  assign bus.in_ready   = ready;
  assign bus.out_valid  = draining;
  assign bus.out_onehot = draining ? top_bit : '0;
  assign bus.out_index  = draining ? top_index : '0;
  assign bus.out_last   = last;
  assign bus.out_count  = count;
  assign bus.busy       = draining;

  // FSM, residual bits and beat counter; later assignments take priority (load > flush > fire).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      resid <= '0;
      count <= '0;
    end else begin
      if (fire) begin
        resid <= resid & ~top_bit;
        count <= count + 1'b1;
        if (last) begin
          state <= IDLE;
        end
      end
      if (flush_drain) begin
        resid <= '0;
        count <= '0;
        state <= IDLE;
      end
      if (accept && draining) begin
        count <= '0;
      end
      if (load) begin
        resid <= bus.in_word;
        count <= '0;
        state <= DRAIN;
      end
    end
  end

endmodule
